cascade_digit_counter: RTL and testbench

//  Parametrised multi-digit base-N up/down counter; chains NUM_DIGITS digit stages with internal

---
 rtl/cascade_digit_counter.sv | 120 ++++++++++++
 tb/tb_cascade_digit_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_digit_counter.sv
// cascade_digit_counter
//   Multi-digit base-BASE up/down counter. NUM_DIGITS digit stages share one
//   clock; every digit's step enable is a flat AND of the lower digits'
//   limit flags, so a full-width carry or borrow settles in a single cycle.
//   Provides synchronous clear, parallel load with per-digit clamping,
//   wrap/saturate at the limits and a registered rollover pulse that can
//   drive the next timing group.
//
// Parameters
//   BASE        radix of every digit (2 .. 2**DIGIT_BITS)
//   DIGIT_BITS  bits per digit
//   NUM_DIGITS  number of digits, digit 0 least significant (1 .. 8)
//   SATURATE    0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   enable      count one step this cycle
//   up_down     1 = count up, 0 = count down
//   clear       synchronous clear to all-zero (highest priority)
//   load        synchronous parallel load of load_value
//   load_value  digit i at [i*DIGIT_BITS +: DIGIT_BITS]
//   count       current digits, same packing as load_value
//   terminal    combinational: count at the limit for the current direction
//   rollover    one-cycle pulse following a wrapping edge
module cascade_digit_counter #(
    parameter int unsigned BASE       = 10,
    parameter int unsigned DIGIT_BITS = 4,
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             up_down,
    input  logic                             clear,
    input  logic                             load,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value,
    output logic [NUM_DIGITS*DIGIT_BITS-1:0] count,
    output logic                             terminal,
    output logic                             rollover
);

    localparam int unsigned             W         = NUM_DIGITS * DIGIT_BITS;
    localparam logic [DIGIT_BITS-1:0]   MAX_DIGIT = DIGIT_BITS'(BASE - 1);
    localparam logic [DIGIT_BITS-1:0]   ONE_DIGIT = DIGIT_BITS'(1);
    localparam bit                      SAT       = (SATURATE != 0);

    logic [W-1:0]          count_q, count_d;
    logic                  rollover_q, rollover_d;
    logic [NUM_DIGITS-1:0] at_max, at_zero;
    logic [NUM_DIGITS-1:0] step_up, step_dn;
    logic                  at_limit;

    always_comb begin : digit_flags
        at_max  = '0;
        at_zero = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            at_max[i]  = (count_q[i*DIGIT_BITS +: DIGIT_BITS] == MAX_DIGIT);
            at_zero[i] = (count_q[i*DIGIT_BITS +: DIGIT_BITS] == '0);
        end
    end

    // Each digit's enable is a direct AND over all lower digits rather than a
    // chain through its neighbour, keeping the carry depth flat.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_step
        if (g == 0) begin : g_lsd
            assign step_up[g] = 1'b1;
            assign step_dn[g] = 1'b1;
        end else begin : g_upper
            assign step_up[g] = &at_max[g-1:0];
            assign step_dn[g] = &at_zero[g-1:0];
        end
    end

    assign at_limit = up_down ? (&at_max) : (&at_zero);

    always_comb begin : next_state
        count_d    = count_q;
        rollover_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (load_value[i*DIGIT_BITS +: DIGIT_BITS] > MAX_DIGIT) begin
                    count_d[i*DIGIT_BITS +: DIGIT_BITS] = MAX_DIGIT;
                end else begin
                    count_d[i*DIGIT_BITS +: DIGIT_BITS] = load_value[i*DIGIT_BITS +: DIGIT_BITS];
                end
            end
        end else if (enable && !(SAT && at_limit)) begin
            // At the limit every digit steps and wraps, giving all-0 / all-MAX.
            rollover_d = at_limit;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (up_down && step_up[i]) begin
                    count_d[i*DIGIT_BITS +: DIGIT_BITS] = at_max[i] ? '0 :
                        count_q[i*DIGIT_BITS +: DIGIT_BITS] + ONE_DIGIT;
                end else if (!up_down && step_dn[i]) begin
                    count_d[i*DIGIT_BITS +: DIGIT_BITS] = at_zero[i] ? MAX_DIGIT :
                        count_q[i*DIGIT_BITS +: DIGIT_BITS] - ONE_DIGIT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    assign count    = count_q;
    assign rollover = rollover_q;
    assign terminal = at_limit;

endmodule

// File: tb/tb_cascade_digit_counter.sv
// Scoreboard bench for cascade_digit_counter: three instances
//   dut 0: BASE 10, 2 digits, wrap
//   dut 1: BASE 10, 2 digits, saturate
//   dut 2: BASE 6,  3 digits, wrap
// The stimulus pushes the expected state visible in the current cycle;
// the monitor pops and compares on the falling edge of that cycle.
module tb_cascade_digit_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en  [3];
    logic        ud  [3];
    logic        clr [3];
    logic        ld  [3];
    logic [11:0] lv  [3];
    logic [7:0]  cnt0, cnt1;
    logic [11:0] cnt2;
    logic        term [3];
    logic        roll [3];

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        int unsigned cyc;
        int          dut;
        logic [11:0] cnt;
        logic        roll;
        logic        term;
        string       nm;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cascade_digit_counter #(.BASE(10), .DIGIT_BITS(4), .NUM_DIGITS(2), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .up_down(ud[0]), .clear(clr[0]),
        .load(ld[0]), .load_value(lv[0][7:0]), .count(cnt0), .terminal(term[0]), .rollover(roll[0])
    );
    cascade_digit_counter #(.BASE(10), .DIGIT_BITS(4), .NUM_DIGITS(2), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .up_down(ud[1]), .clear(clr[1]),
        .load(ld[1]), .load_value(lv[1][7:0]), .count(cnt1), .terminal(term[1]), .rollover(roll[1])
    );
    cascade_digit_counter #(.BASE(6), .DIGIT_BITS(4), .NUM_DIGITS(3), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .up_down(ud[2]), .clear(clr[2]),
        .load(ld[2]), .load_value(lv[2]), .count(cnt2), .terminal(term[2]), .rollover(roll[2])
    );

    function automatic logic [11:0] dut_count(int d);
        case (d)
            0:       return {4'h0, cnt0};
            1:       return {4'h0, cnt1};
            default: return cnt2;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s dut%0d: expectation for cycle %0d missed, now cycle %0d",
                         e.nm, e.dut, e.cyc, cyc);
            end else begin
                n_checks++;
                if (dut_count(e.dut) !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s dut%0d count: got %h expected %h", e.nm, e.dut,
                             dut_count(e.dut), e.cnt);
                end
                n_checks++;
                if (roll[e.dut] !== e.roll) begin
                    n_fail++;
                    $display("FAIL %s dut%0d rollover: got %b expected %b", e.nm, e.dut,
                             roll[e.dut], e.roll);
                end
                n_checks++;
                if (term[e.dut] !== e.term) begin
                    n_fail++;
                    $display("FAIL %s dut%0d terminal: got %b expected %b", e.nm, e.dut,
                             term[e.dut], e.term);
                end
            end
        end
    end

    task automatic drive(int d, logic e, logic u, logic c, logic l, logic [11:0] v);
        en[d]  = e;
        ud[d]  = u;
        clr[d] = c;
        ld[d]  = l;
        lv[d]  = v;
    endtask

    task automatic expect_now(int d, string nm, logic [11:0] c, logic r, logic t);
        exp_t x;
        x.cyc  = cyc;
        x.dut  = d;
        x.cnt  = c;
        x.roll = r;
        x.term = t;
        x.nm   = nm;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, expect the state visible this cycle, then clock.
    task automatic step(int d, string nm, logic e, logic u, logic c, logic l, logic [11:0] v,
                        logic [11:0] ec, logic er, logic et);
        drive(d, e, u, c, l, v);
        expect_now(d, nm, ec, er, et);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();

        // Reset with enable toggling
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 3; d++) begin
                drive(d, (k % 2) == 1, k >= 2, 1'b0, 1'b0, 12'h000);
                expect_now(d, "reset", 12'h000, 1'b0, k < 2);
            end
            tick();
        end
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        rst_n = 1'b1;

        // Up wrap, BASE 10
        step(0, "up_ld98",    0, 1, 0, 1, 12'h098, 12'h000, 0, 0);
        step(0, "up_98",      1, 1, 0, 0, 12'h000, 12'h098, 0, 0);
        step(0, "up_99",      1, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(0, "up_wrap",    0, 1, 0, 0, 12'h000, 12'h000, 1, 0);
        step(0, "up_rollend", 0, 1, 0, 0, 12'h000, 12'h000, 0, 0);

        // Down borrow and down wrap
        step(0, "dn_ld10",    0, 0, 0, 1, 12'h010, 12'h000, 0, 1);
        step(0, "dn_10",      1, 0, 0, 0, 12'h000, 12'h010, 0, 0);
        step(0, "dn_09",      1, 0, 0, 0, 12'h000, 12'h009, 0, 0);
        step(0, "dn_08",      0, 0, 0, 1, 12'h000, 12'h008, 0, 0);
        step(0, "dn_00",      1, 0, 0, 0, 12'h000, 12'h000, 0, 1);
        step(0, "dn_wrap",    0, 1, 0, 1, 12'h099, 12'h099, 1, 1);

        // Wraps from loaded limit, each with its own pulse
        step(0, "up_99b",     1, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(0, "up_wrap2",   0, 1, 0, 1, 12'h099, 12'h000, 1, 0);
        step(0, "up_99c",     1, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(0, "up_wrap3",   0, 1, 0, 0, 12'h000, 12'h000, 1, 0);

        // Priority and clamp
        step(0, "pri_all",    1, 1, 1, 1, 12'h057, 12'h000, 0, 0);
        step(0, "pri_ld_en",  1, 1, 0, 1, 12'h057, 12'h000, 0, 0);
        step(0, "pri_57",     0, 1, 0, 1, 12'h03F, 12'h057, 0, 0);
        step(0, "clamp_39",   0, 1, 0, 1, 12'h0AF, 12'h039, 0, 0);
        step(0, "clamp_99",   0, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(0, "hold_99",    0, 0, 0, 0, 12'h000, 12'h099, 0, 0);

        // Saturating instance
        step(1, "sat_ld99",   0, 1, 0, 1, 12'h099, 12'h000, 0, 0);
        step(1, "sat_99a",    1, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(1, "sat_99b",    1, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(1, "sat_99c",    1, 1, 0, 0, 12'h000, 12'h099, 0, 1);
        step(1, "sat_99d",    0, 0, 0, 1, 12'h000, 12'h099, 0, 0);
        step(1, "sat_00a",    1, 0, 0, 0, 12'h000, 12'h000, 0, 1);
        step(1, "sat_00b",    1, 0, 0, 0, 12'h000, 12'h000, 0, 1);
        step(1, "sat_00c",    1, 1, 0, 0, 12'h000, 12'h000, 0, 0);
        step(1, "sat_01",     0, 1, 0, 0, 12'h000, 12'h001, 0, 0);

        // BASE 6, 3 digits
        step(2, "b6_ld554",   0, 1, 0, 1, 12'h554, 12'h000, 0, 0);
        step(2, "b6_554",     1, 1, 0, 0, 12'h000, 12'h554, 0, 0);
        step(2, "b6_555",     1, 1, 0, 0, 12'h000, 12'h555, 0, 1);
        step(2, "b6_wrap",    0, 1, 0, 0, 12'h000, 12'h000, 1, 0);
        step(2, "b6_ld100",   0, 0, 0, 1, 12'h100, 12'h000, 0, 1);
        step(2, "b6_100",     1, 0, 0, 0, 12'h000, 12'h100, 0, 0);
        step(2, "b6_055",     1, 0, 0, 0, 12'h000, 12'h055, 0, 0);
        step(2, "b6_054",     0, 1, 0, 1, 12'h045, 12'h054, 0, 0);
        step(2, "b6_045",     1, 1, 0, 0, 12'h000, 12'h045, 0, 0);
        step(2, "b6_050",     0, 1, 0, 1, 12'hF9C, 12'h050, 0, 0);
        step(2, "b6_clamp555",0, 1, 0, 1, 12'h162, 12'h555, 0, 1);
        step(2, "b6_clamp152",0, 0, 0, 1, 12'h000, 12'h152, 0, 0);
        step(2, "b6_000",     1, 0, 0, 0, 12'h000, 12'h000, 0, 1);
        step(2, "b6_dwrap",   0, 0, 0, 0, 12'h000, 12'h555, 1, 0);

        // Asynchronous reset mid-operation, then first counting edge
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        expect_now(0, "rst_async", 12'h000, 0, 0);
        expect_now(2, "rst_async_b6", 12'h000, 0, 1);
        tick();
        expect_now(0, "rst_hold", 12'h000, 0, 0);
        rst_n = 1'b1;
        tick();
        expect_now(0, "rst_first", 12'h001, 0, 0);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        tick();
        tick();

        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s dut%0d: expectation for cycle %0d never checked", x.nm, x.dut, x.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
